// File: rtl/bcd_addsub_seq_if.sv
// Request/response bundle for the chunk-serial BCD add/subtract sequencer.
// master drives the request side, slave is the sequencer itself.
interface bcd_addsub_seq_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    i_start;
  logic                    i_op;
  logic                    i_sign_a;
  logic [NUM_DIGITS*4-1:0] i_num_a;
  logic                    i_sign_b;
  logic [NUM_DIGITS*4-1:0] i_num_b;
  logic                    o_ready;
  logic                    o_valid;
  logic                    o_sign;
  logic [NUM_DIGITS*4-1:0] o_num;
  logic                    o_overflow;
  logic                    o_invalid;

  modport master (
    output i_start, i_op, i_sign_a, i_num_a, i_sign_b, i_num_b,
    input  o_ready, o_valid, o_sign, o_num, o_overflow, o_invalid
  );

  modport slave (
    input  i_start, i_op, i_sign_a, i_num_a, i_sign_b, i_num_b,
    output o_ready, o_valid, o_sign, o_num, o_overflow, o_invalid
  );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Sign-magnitude BCD add/subtract that reuses one CHUNK_DIGITS-wide BCD adder
// over NUM_DIGITS/CHUNK_DIGITS cycles, with nine's-complement subtraction and recomplement.
module bcd_adder #(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4-1:0] a,
  input  logic [DIGITS*4-1:0] b,
  input  logic                cin,
  output logic [DIGITS*4-1:0] sum,
  output logic                cout
);
  logic [DIGITS:0] c;
  genvar gi;

  assign c[0] = cin;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [4:0] raw;
      assign raw       = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]} + {4'd0, c[gi]};
      assign c[gi+1]   = (raw > 5'd9);
      // Adding 6 modulo 16 folds a decimal carry back into a valid digit.
      assign sum[gi*4 +: 4] = raw[3:0] + (c[gi+1] ? 4'd6 : 4'd0);
    end
  endgenerate
  assign cout = c[DIGITS];
endmodule

module bcd_addsub_seq #(
  parameter int NUM_DIGITS   = 8,
  parameter int CHUNK_DIGITS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bcd_addsub_seq_if.slave    bus
);
  localparam int P  = NUM_DIGITS / CHUNK_DIGITS;
  localparam int W  = NUM_DIGITS * 4;
  localparam int CW = CHUNK_DIGITS * 4;
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, ADD, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, a_next, b_reg, b_next;
  logic [W-1:0]    res_reg, res_next, num_reg, num_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            carry_reg, carry_next, eff_sub_reg, eff_sub_next;
  logic            sign_a_reg, sign_a_next, res_sign_reg, res_sign_next;
  logic            sign_reg, sign_next, ovf_reg, ovf_next, inv_reg, inv_next;

  logic [CW-1:0]   a_chunks [P];
  logic [CW-1:0]   b_chunks [P];
  logic [CW-1:0]   r_chunks [P];
  logic [CW-1:0]   add_a, add_b, add_sum;
  logic            add_cout, wr_en, last_chunk;
  logic [NUM_DIGITS-1:0] bad_digit;
  genvar gi;

  function automatic logic [CW-1:0] nines(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CHUNK_DIGITS; i++) r[i*4 +: 4] = 4'd9 - v[i*4 +: 4];
    return r;
  endfunction

  generate
    for (gi = 0; gi < P; gi++) begin : g_chunk
      assign a_chunks[gi] = a_reg[gi*CW +: CW];
      assign b_chunks[gi] = b_reg[gi*CW +: CW];
      assign r_chunks[gi] = res_reg[gi*CW +: CW];
      assign res_next[gi*CW +: CW] = (wr_en && idx_reg == IW'(gi)) ? add_sum
                                                                   : res_reg[gi*CW +: CW];
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_bad
      assign bad_digit[gi] = (a_reg[gi*4 +: 4] > 4'd9) || (b_reg[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  assign wr_en      = (state_reg == ADD) || (state_reg == FIX);
  assign last_chunk = (idx_reg == IW'(P - 1));
  // FIX turns a ten's-complement result back into a magnitude: 0 + nines(r) + 1.
  assign add_a = (state_reg == FIX) ? '0 : a_chunks[idx_reg];
  assign add_b = (state_reg == FIX) ? nines(r_chunks[idx_reg])
                                    : (eff_sub_reg ? nines(b_chunks[idx_reg]) : b_chunks[idx_reg]);

  bcd_adder #(.DIGITS(CHUNK_DIGITS)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    idx_next      = idx_reg;
    carry_next    = carry_reg;
    eff_sub_next  = eff_sub_reg;
    sign_a_next   = sign_a_reg;
    res_sign_next = res_sign_reg;
    num_next      = num_reg;
    sign_next     = sign_reg;
    ovf_next      = ovf_reg;
    inv_next      = inv_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          a_next       = bus.i_num_a;
          b_next       = bus.i_num_b;
          sign_a_next  = bus.i_sign_a;
          eff_sub_next = bus.i_sign_a ^ bus.i_sign_b ^ bus.i_op;
          carry_next   = bus.i_sign_a ^ bus.i_sign_b ^ bus.i_op;
          idx_next     = '0;
          ovf_next     = 1'b0;
          inv_next     = 1'b0;
          state_next   = CHECK;
        end
      end
      CHECK: begin
        if (|bad_digit) begin
          inv_next   = 1'b1;
          num_next   = '0;
          sign_next  = 1'b0;
          state_next = DONE;
        end else begin
          state_next = ADD;
        end
      end
      ADD: begin
        carry_next = add_cout;
        idx_next   = idx_reg + IW'(1);
        if (last_chunk) begin
          idx_next = '0;
          if (!eff_sub_reg || add_cout) begin
            ovf_next   = add_cout & ~eff_sub_reg;
            num_next   = res_next;
            sign_next  = sign_a_reg & (res_next != '0);
            state_next = DONE;
          end else begin
            // No end-around carry: |B| > |A|, so the magnitude needs recomplementing.
            res_sign_next = ~sign_a_reg;
            carry_next    = 1'b1;
            state_next    = FIX;
          end
        end
      end
      FIX: begin
        carry_next = add_cout;
        idx_next   = idx_reg + IW'(1);
        if (last_chunk) begin
          idx_next   = '0;
          num_next   = res_next;
          sign_next  = res_sign_reg & (res_next != '0);
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      eff_sub_reg  <= 1'b0;
      sign_a_reg   <= 1'b0;
      res_sign_reg <= 1'b0;
      num_reg      <= '0;
      sign_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      inv_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      res_reg      <= res_next;
      idx_reg      <= idx_next;
      carry_reg    <= carry_next;
      eff_sub_reg  <= eff_sub_next;
      sign_a_reg   <= sign_a_next;
      res_sign_reg <= res_sign_next;
      num_reg      <= num_next;
      sign_reg     <= sign_next;
      ovf_reg      <= ovf_next;
      inv_reg      <= inv_next;
    end
  end

  assign bus.o_ready    = (state_reg == IDLE);
  assign bus.o_valid    = (state_reg == DONE);
  assign bus.o_num      = num_reg;
  assign bus.o_sign     = sign_reg;
  assign bus.o_overflow = ovf_reg;
  assign bus.o_invalid  = inv_reg;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed-vector bench for bcd_addsub_seq (8 digits, 4-digit chunks).
// Each transaction checks latency, result fields, pulse width and output hold.
module tb_bcd_addsub_seq;
  localparam int ND = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_addsub_seq_if #(.NUM_DIGITS(ND)) bus ();

  bcd_addsub_seq #(.NUM_DIGITS(ND), .CHUNK_DIGITS(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.o_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // poke: re-pulse i_start while busy and again during the DONE cycle.
  task automatic run_op(input string tag, input logic op, input logic sa, input logic [31:0] na,
                        input logic sb, input logic [31:0] nb, input logic [31:0] exp_num,
                        input logic exp_sign, input logic exp_ovf, input logic exp_inv,
                        input int exp_lat, input bit poke);
    int lat;
    wait_ready(tag);
    @(negedge clk);
    bus.i_op = op; bus.i_sign_a = sa; bus.i_num_a = na;
    bus.i_sign_b = sb; bus.i_num_b = nb; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    // Inputs after the accept edge must not matter.
    bus.i_num_a = 32'h5555_5555; bus.i_num_b = 32'h1111_1111;
    bus.i_sign_a = ~sa; bus.i_op = ~op;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (bus.o_valid) break;
      if (poke) bus.i_start = (lat == 1);
      if (poke && lat == 1) check({tag, "_busy_ready"}, 32'(bus.o_ready), 32'd0);
    end
    bus.i_start = 1'b0;
    if (!bus.o_valid) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_num"}, bus.o_num, exp_num);
    check({tag, "_sign"}, 32'(bus.o_sign), 32'(exp_sign));
    check({tag, "_ovf"}, 32'(bus.o_overflow), 32'(exp_ovf));
    check({tag, "_inv"}, 32'(bus.o_invalid), 32'(exp_inv));
    $display("txn %s lat=%0d num=%h sign=%0d ovf=%0d inv=%0d", tag, lat, bus.o_num,
             bus.o_sign, bus.o_overflow, bus.o_invalid);
    if (poke) bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check({tag, "_pulse"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_hold"}, bus.o_num, exp_num);
  endtask

  initial begin
    int vcount;
    bus.i_start = 1'b0; bus.i_op = 1'b0;
    bus.i_sign_a = 1'b0; bus.i_num_a = '0;
    bus.i_sign_b = 1'b0; bus.i_num_b = '0;
    #12;
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_num", bus.o_num, 32'd0);
    check("rst_flags", {29'd0, bus.o_sign, bus.o_overflow, bus.o_invalid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_nines", 0, 0, 32'h1234_5678, 0, 32'h8765_4321, 32'h9999_9999, 0, 0, 0, 3, 0);
    run_op("add_ovf",   0, 0, 32'h9999_9999, 0, 32'h0000_0001, 32'h0000_0000, 0, 1, 0, 3, 0);
    run_op("sub_pos",   1, 0, 32'h0000_0100, 0, 32'h0000_0001, 32'h0000_0099, 0, 0, 0, 3, 0);
    run_op("sub_neg",   1, 0, 32'h0000_0001, 0, 32'h0000_0100, 32'h0000_0099, 1, 0, 0, 5, 0);
    run_op("neg_zero",  0, 1, 32'h0000_0005, 0, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, 3, 0);
    run_op("neg_sub",   1, 1, 32'h0000_0007, 1, 32'h0000_0002, 32'h0000_0005, 1, 0, 0, 3, 0);
    run_op("mix_fix",   0, 1, 32'h0000_0003, 0, 32'h0000_0008, 32'h0000_0005, 0, 0, 0, 5, 0);
    run_op("borrow",    1, 0, 32'h1000_0000, 0, 32'h0000_0001, 32'h0999_9999, 0, 0, 0, 3, 0);
    run_op("invalid",   0, 0, 32'h0000_0001, 0, 32'h0000_000A, 32'h0000_0000, 0, 0, 1, 1, 0);
    run_op("busy",      0, 0, 32'h1234_5678, 0, 32'h0000_0001, 32'h1234_5679, 0, 0, 0, 3, 1);

    // Abort an operation while it is recomplementing.
    wait_ready("abort");
    @(negedge clk);
    bus.i_op = 1'b1; bus.i_sign_a = 1'b0; bus.i_num_a = 32'h0000_0001;
    bus.i_sign_b = 1'b0; bus.i_num_b = 32'h0000_0100; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.o_ready), 32'd1);
    check("abort_valid", 32'(bus.o_valid), 32'd0);
    check("abort_num", bus.o_num, 32'd0);
    check("abort_flags", {29'd0, bus.o_sign, bus.o_overflow, bus.o_invalid}, 32'd0);
    $display("txn abort num=%h ready=%0d", bus.o_num, bus.o_ready);
    @(negedge clk); rst_n = 1'b1;
    vcount = 0;
    repeat (8) begin @(posedge clk); #1; if (bus.o_valid) vcount++; end
    check("abort_no_valid", 32'(vcount), 32'd0);

    run_op("after_rst", 0, 0, 32'h0000_0250, 0, 32'h0000_0750, 32'h0000_1000, 0, 0, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
- Chunk-serial sign-magnitude BCD add/subtract sequencer for the RPN calculator's arithmetic unit.
- Instantiates one bcd_adder of CHUNK_DIGITS digits and reuses it over several cycles to process NUM_DIGITS-digit operands.
- Handles the sign logic, nine's-complement subtraction, recomplementing of negative results and overflow detection.
- Fronted by a start/ready request and a one-cycle valid pulse on completion.

Parameters:
- NUM_DIGITS, 8: operand/result width in BCD digits.
- CHUNK_DIGITS, 4: digits processed per cycle (width of the shared bcd_adder). Must divide NUM_DIGITS. P = NUM_DIGITS/CHUNK_DIGITS passes.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request; accepted on an edge where i_start=1 and o_ready=1.
- i_op  in  1  0 = A+B, 1 = A-B.
- i_sign_a  in  1  sign of A (1 = negative).
- i_num_a  in  NUM_DIGITS*4  magnitude of A, BCD.
- i_sign_b  in  1  sign of B.
- i_num_b  in  NUM_DIGITS*4  magnitude of B, BCD.
- o_ready  out  1  high in IDLE only.
- o_valid  out  1  one-cycle pulse; result outputs are valid.
- o_sign  out  1  result sign.
- o_num  out  NUM_DIGITS*4  result magnitude, BCD.
- o_overflow  out  1  magnitude exceeded NUM_DIGITS digits.
- o_invalid  out  1  an input digit was greater than 9.

Behaviour:
- Reset (async, any state): state=IDLE, o_ready=1, o_valid=0, o_sign=0, o_num=0, o_overflow=0, o_invalid=0. Internal registers and carry cleared. An aborted operation produces no o_valid.
- On accept:
  - Latch operands.
  - eff_sub = i_sign_a ^ i_sign_b ^ i_op.
  - Carry register = eff_sub.
  - Chunk index = 0.
  - Clear o_overflow and o_invalid.
- If any latched nibble of A or B is greater than 9: go to DONE next.
  - o_invalid=1, o_num=0, o_sign=0.
  - Latency 1 cycle.
- ADD state, one chunk per cycle from the least significant chunk:
  - Adder input a = chunk of A.
  - Adder input b = chunk of B, or its nine's complement (9-d per digit) when eff_sub.
  - Adder carry-in = carry register; carry register <= adder carry-out.
  - Result chunk is written to the result register.
  - After P cycles, the final carry-out C decides the outcome:
    - eff_sub=0: o_overflow=C, sign=sign_a, go to DONE.
    - eff_sub=1 and C=1: the result is |A|-|B| >= 0, sign=sign_a, go to DONE.
    - eff_sub=1 and C=0: the result is negative in ten's-complement form; sign=~sign_a, go to FIX.
- FIX state, P cycles, recomplementing:
  - Adder a = 0, b = nine's complement of the result chunk.
  - Carry-in is 1 on the first chunk, then propagated.
  - The result chunk is overwritten.
- DONE state, one cycle:
  - o_valid=1.
  - o_num, o_sign, o_overflow and o_invalid update in this cycle and hold until the next accept.
  - If o_num==0, o_sign is forced to 0 (no negative zero).
  - Next state IDLE.
- Latency from the accept edge to o_valid high:
  - P+1 cycles with no FIX.
  - 2P+1 cycles with FIX.
  - 1 cycle for invalid input.
- i_start while o_ready=0 is ignored. There is no queuing.
- i_start in the DONE cycle is ignored. A new request can be accepted on the next cycle (IDLE).
- Inputs are only sampled on the accept edge; later changes to them have no effect.
- Adder width is CHUNK_DIGITS*4 bits. Nine's complement is applied per nibble.
- Overflow is possible only on effective add. When o_overflow=1, o_num carries the low NUM_DIGITS digits.

Test Plan (NUM_DIGITS=8, CHUNK_DIGITS=4, P=2):
- +12345678 + +87654321 (op=0) -> o_num=99999999, o_sign=0, o_overflow=0; o_valid 3 cycles after accept.
- +99999999 + +00000001 -> o_num=00000000, o_sign=0, o_overflow=1, 3 cycles; the carry crosses the chunk boundary.
- +00000100 - +00000001 -> o_num=00000099, o_sign=0, 3 cycles. Then +00000001 - +00000100 -> o_num=00000099, o_sign=1, 5 cycles (FIX path).
- -00000005 + +00000005 -> o_num=0, o_sign=0 (no negative zero). Also -00000007 - -00000002 -> o_num=00000005, o_sign=1.
- i_num_b=0000000A -> o_invalid=1, o_num=0, o_valid 1 cycle after accept.
- Pulse i_start while busy -> ignored, and the first result is unchanged.
- Assert i_rst_n=0 during FIX -> outputs immediately go to reset values, no o_valid pulse; the next request then completes normally.
